// File: rtl/mul_unit_ctrl.sv
// mul_unit_ctrl: sequences one RV32M multiply at a time from the reservation
// station through the shared shift-add multiplier and holds the selected
// result half until the CDB arbiter grants its broadcast.
module mul_unit_ctrl #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_rs1_v,
  input  logic [XLEN-1:0]      req_rs2_v,
  input  logic [ROB_IDX_W-1:0] req_rob_idx,
  input  logic [PREG_W-1:0]    req_pd,
  input  logic [4:0]           req_rd,
  output logic                 mul_start,
  output logic [1:0]           mul_type,
  output logic [XLEN-1:0]      mul_a,
  output logic [XLEN-1:0]      mul_b,
  output logic                 mul_flush,
  input  logic [2*XLEN-1:0]    mul_p,
  input  logic                 mul_done,
  output logic                 cdb_valid,
  input  logic                 cdb_grant,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [PREG_W-1:0]    cdb_pd,
  output logic [4:0]           cdb_rd,
  output logic [XLEN-1:0]      cdb_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESULT
  } state_t;

  state_t     state;
  logic       hi_sel;
  logic       accept;
  logic [1:0] dec_type;
  logic       dec_hi;
  logic       funct3_unused;

  // Only funct3[1:0] distinguishes the four multiply flavours.
  assign funct3_unused = req_funct3[2];

  // The multiplier is flushed together with this controller.
  assign mul_flush = flush;

  // A new op is taken when idle, or when the held result leaves this cycle;
  // flush and reset both refuse it.
  assign req_ready = rst && !flush &&
                     ((state == IDLE) || ((state == RESULT) && cdb_grant));
  assign accept    = req_valid && req_ready;

  // Map funct3 to multiplier signedness and to which product half is kept.
  always_comb begin
    dec_type = 2'b01;
    dec_hi   = 1'b1;
    case (req_funct3[1:0])
      2'b00:   begin dec_type = 2'b01; dec_hi = 1'b0; end
      2'b01:   dec_type = 2'b01;
      2'b10:   dec_type = 2'b10;
      default: dec_type = 2'b00;
    endcase
  end

  // Controller state machine; every output it drives is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hi_sel      <= 1'b0;
      mul_start   <= 1'b0;
      mul_type    <= 2'b00;
      mul_a       <= '0;
      mul_b       <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_pd      <= '0;
      cdb_rd      <= '0;
      cdb_data    <= '0;
      busy        <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      hi_sel      <= 1'b0;
      mul_start   <= 1'b0;
      mul_type    <= 2'b00;
      mul_a       <= '0;
      mul_b       <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_pd      <= '0;
      cdb_rd      <= '0;
      cdb_data    <= '0;
      busy        <= 1'b0;
    end else if (accept) begin
      state       <= BUSY;
      hi_sel      <= dec_hi;
      mul_start   <= 1'b1;
      mul_type    <= dec_type;
      mul_a       <= req_rs1_v;
      mul_b       <= req_rs2_v;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= req_rob_idx;
      cdb_pd      <= req_pd;
      cdb_rd      <= req_rd;
      busy        <= 1'b1;
    end else begin
      case (state)
        BUSY: begin
          if (mul_done) begin
            state     <= RESULT;
            mul_start <= 1'b0;
            cdb_valid <= 1'b1;
            cdb_data  <= hi_sel ? mul_p[2*XLEN-1:XLEN] : mul_p[XLEN-1:0];
          end
        end
        RESULT: begin
          if (cdb_grant) begin
            state     <= IDLE;
            cdb_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
